// File: rtl/ex_mem_skid.sv
// ex_mem_skid: two-entry skid buffer between the EX and MEM pipeline stages.
// HEAD drives the MEM-side outputs and SKID holds a younger entry. ex_ready_o
// depends only on registered state, which breaks the combinational ready path
// from MEM back to EX.
module ex_mem_skid #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [DATA_W-1:0] ex_alu_result_i,
    input  logic [DATA_W-1:0] ex_rs2_data_i,
    input  logic [DATA_W-1:0] ex_pc_i,
    input  logic [4:0]        ex_rd_addr_i,
    input  logic              ex_rd_wren_i,
    input  logic              ex_mem_wren_i,
    input  logic              ex_mem_rden_i,
    input  logic              flush_i,
    input  logic              mem_ready_i,
    output logic              mem_valid_o,
    output logic [DATA_W-1:0] mem_alu_result_o,
    output logic [DATA_W-1:0] mem_rs2_data_o,
    output logic [DATA_W-1:0] mem_pc_o,
    output logic [4:0]        mem_rd_addr_o,
    output logic              mem_rd_wren_o,
    output logic              mem_mem_wren_o,
    output logic              mem_mem_rden_o,
    output logic [31:0]       busy_rd_mask_o,
    output logic [1:0]        occupancy_o
);

    // Entry layout, MSB first: alu_result, rs2_data, pc, rd_addr, rd_wren, mem_wren, mem_rden
    localparam int ENTRY_W = 3 * DATA_W + 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [ENTRY_W-1:0] head_reg;
    logic [ENTRY_W-1:0] skid_reg;
    logic [ENTRY_W-1:0] in_entry;
    logic               accept;
    logic               pop;
    logic               head_valid;
    logic               skid_valid;

    // x0 is never a real destination, so its write enable is dropped on entry
    assign in_entry = {ex_alu_result_i, ex_rs2_data_i, ex_pc_i, ex_rd_addr_i,
                       ex_rd_wren_i & (ex_rd_addr_i != 5'd0),
                       ex_mem_wren_i, ex_mem_rden_i};

    assign head_valid = (state_reg != EMPTY);
    assign skid_valid = (state_reg == FULL);
    assign ex_ready_o = (state_reg != FULL);
    assign accept     = ex_valid_i & ex_ready_o;
    assign pop        = head_valid & mem_ready_i;

    // Occupancy state and entry storage; reset beats flush, and flush beats accept/pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= EMPTY;
            head_reg  <= '0;
            skid_reg  <= '0;
        end else if (flush_i) begin
            state_reg <= EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        head_reg  <= in_entry;
                        state_reg <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_reg <= in_entry;
                    end else if (accept) begin
                        skid_reg  <= in_entry;
                        state_reg <= FULL;
                    end else if (pop) begin
                        state_reg <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_reg  <= skid_reg;
                        state_reg <= ONE;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

    // Head fields drive MEM; control strobes are masked whenever the head is empty
    assign mem_valid_o      = head_valid;
    assign mem_alu_result_o = head_reg[ENTRY_W-1 -: DATA_W];
    assign mem_rs2_data_o   = head_reg[2*DATA_W+7 -: DATA_W];
    assign mem_pc_o         = head_reg[DATA_W+7 -: DATA_W];
    assign mem_rd_addr_o    = head_reg[7:3];
    assign mem_rd_wren_o    = head_valid & head_reg[2];
    assign mem_mem_wren_o   = head_valid & head_reg[1];
    assign mem_mem_rden_o   = head_valid & head_reg[0];

    assign occupancy_o = {skid_valid, head_valid & ~skid_valid};

    // Pending-write scoreboard bits for the hazard unit; register 0 is never busy
    assign busy_rd_mask_o[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            assign busy_rd_mask_o[gi] =
                (head_valid & head_reg[2] & (head_reg[7:3] == 5'(gi))) |
                (skid_valid & skid_reg[2] & (skid_reg[7:3] == 5'(gi)));
        end
    endgenerate

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: directed-vector bench for the EX/MEM skid buffer.
module tb_ex_mem_skid;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_rs2_data;
    logic [DATA_W-1:0] ex_pc;
    logic [4:0]        ex_rd_addr;
    logic              ex_rd_wren;
    logic              ex_mem_wren;
    logic              ex_mem_rden;
    logic              flush;
    logic              mem_ready;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_rs2_data;
    logic [DATA_W-1:0] mem_pc;
    logic [4:0]        mem_rd_addr;
    logic              mem_rd_wren;
    logic              mem_mem_wren;
    logic              mem_mem_rden;
    logic [31:0]       busy_rd_mask;
    logic [1:0]        occupancy;

    int check_count = 0;
    int error_count = 0;

    ex_mem_skid #(.DATA_W(DATA_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .ex_valid_i       (ex_valid),
        .ex_ready_o       (ex_ready),
        .ex_alu_result_i  (ex_alu_result),
        .ex_rs2_data_i    (ex_rs2_data),
        .ex_pc_i          (ex_pc),
        .ex_rd_addr_i     (ex_rd_addr),
        .ex_rd_wren_i     (ex_rd_wren),
        .ex_mem_wren_i    (ex_mem_wren),
        .ex_mem_rden_i    (ex_mem_rden),
        .flush_i          (flush),
        .mem_ready_i      (mem_ready),
        .mem_valid_o      (mem_valid),
        .mem_alu_result_o (mem_alu_result),
        .mem_rs2_data_o   (mem_rs2_data),
        .mem_pc_o         (mem_pc),
        .mem_rd_addr_o    (mem_rd_addr),
        .mem_rd_wren_o    (mem_rd_wren),
        .mem_mem_wren_o   (mem_mem_wren),
        .mem_mem_rden_o   (mem_mem_rden),
        .busy_rd_mask_o   (busy_rd_mask),
        .occupancy_o      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%0h", tag, observed);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an EX instruction; rs2 and pc are derived from the result value
    task automatic drive_ex(input logic valid, input logic [31:0] alu, input logic [4:0] rd,
                            input logic rd_wren, input logic mem_wren, input logic mem_rden);
        ex_valid      = valid;
        ex_alu_result = alu;
        ex_rs2_data   = alu ^ 32'hFFFF_0000;
        ex_pc         = alu + 32'h0000_1000;
        ex_rd_addr    = rd;
        ex_rd_wren    = rd_wren;
        ex_mem_wren   = mem_wren;
        ex_mem_rden   = mem_rden;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        mem_ready = 1'b0;
        drive_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_val("rst_ex_ready", 64'(ex_ready), 64'd1);
        check_val("rst_mem_valid", 64'(mem_valid), 64'd0);
        check_val("rst_occupancy", 64'(occupancy), 64'd0);
        check_val("rst_busy_mask", 64'(busy_rd_mask), 64'd0);
        check_val("rst_alu", 64'(mem_alu_result), 64'd0);

        // Single entry passes through with one cycle latency
        mem_ready = 1'b1;
        drive_ex(1'b1, 32'h0000_0F00, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        drive_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("pass_valid", 64'(mem_valid), 64'd1);
        check_val("pass_alu", 64'(mem_alu_result), 64'h0000_0F00);
        check_val("pass_rs2", 64'(mem_rs2_data), 64'hFFFF_0F00);
        check_val("pass_pc", 64'(mem_pc), 64'h0000_1F00);
        check_val("pass_rd", 64'(mem_rd_addr), 64'd5);
        check_val("pass_rd_wren", 64'(mem_rd_wren), 64'd1);
        check_val("pass_busy_mask", 64'(busy_rd_mask), 64'h0000_0020);
        check_val("pass_occupancy", 64'(occupancy), 64'd1);
        step();
        check_val("pass_drain_valid", 64'(mem_valid), 64'd0);
        check_val("pass_drain_occ", 64'(occupancy), 64'd0);
        check_val("pass_drain_rd_wren", 64'(mem_rd_wren), 64'd0);

        // Fill both entries while MEM is stalled
        mem_ready = 1'b0;
        drive_ex(1'b1, 32'h0000_000A, 5'd3, 1'b1, 1'b0, 1'b0);
        step();
        check_val("fill_ready_one", 64'(ex_ready), 64'd1);
        drive_ex(1'b1, 32'h0000_000B, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        check_val("full_occupancy", 64'(occupancy), 64'd2);
        check_val("full_ex_ready", 64'(ex_ready), 64'd0);
        check_val("full_busy_mask", 64'(busy_rd_mask), 64'h0000_0088);
        check_val("full_head_alu", 64'(mem_alu_result), 64'h0000_000A);
        // A further offer while full must be refused and the head held stable
        drive_ex(1'b1, 32'h0000_DEAD, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        drive_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("stall_head_alu", 64'(mem_alu_result), 64'h0000_000A);
        check_val("stall_head_rd", 64'(mem_rd_addr), 64'd3);
        check_val("stall_occupancy", 64'(occupancy), 64'd2);
        // Drain: A was at the head, B follows on the next cycle
        mem_ready = 1'b1;
        step();
        check_val("drain_b_alu", 64'(mem_alu_result), 64'h0000_000B);
        check_val("drain_b_rd", 64'(mem_rd_addr), 64'd7);
        check_val("drain_b_mem_wren", 64'(mem_mem_wren), 64'd1);
        check_val("drain_b_occ", 64'(occupancy), 64'd1);
        check_val("drain_b_mask", 64'(busy_rd_mask), 64'h0000_0080);
        step();
        check_val("drain_empty_occ", 64'(occupancy), 64'd0);

        // Simultaneous accept and pop in ONE
        mem_ready = 1'b0;
        drive_ex(1'b1, 32'h0000_0011, 5'd4, 1'b1, 1'b0, 1'b0);
        step();
        check_val("one_head_alu", 64'(mem_alu_result), 64'h0000_0011);
        mem_ready = 1'b1;
        drive_ex(1'b1, 32'h0000_0022, 5'd6, 1'b1, 1'b0, 1'b0);
        step();
        drive_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        mem_ready = 1'b0;
        check_val("swap_head_alu", 64'(mem_alu_result), 64'h0000_0022);
        check_val("swap_occupancy", 64'(occupancy), 64'd1);
        check_val("swap_mask", 64'(busy_rd_mask), 64'h0000_0040);
        step();
        check_val("swap_hold_occ", 64'(occupancy), 64'd1);
        mem_ready = 1'b1;
        step();
        check_val("swap_drain_occ", 64'(occupancy), 64'd0);

        // Destination x0 never marks a pending write
        mem_ready = 1'b0;
        drive_ex(1'b1, 32'h0000_0033, 5'd0, 1'b1, 1'b0, 1'b1);
        step();
        check_val("x0_valid", 64'(mem_valid), 64'd1);
        check_val("x0_rd_wren", 64'(mem_rd_wren), 64'd0);
        check_val("x0_mask", 64'(busy_rd_mask), 64'd0);
        check_val("x0_mem_rden", 64'(mem_mem_rden), 64'd1);

        // Flush from FULL overrides a same-cycle accept and pop
        drive_ex(1'b1, 32'h0000_0044, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        check_val("pre_flush_occ", 64'(occupancy), 64'd2);
        check_val("pre_flush_mask", 64'(busy_rd_mask), 64'h0000_0200);
        flush = 1'b1;
        mem_ready = 1'b1;
        drive_ex(1'b1, 32'h0000_0055, 5'd11, 1'b1, 1'b0, 1'b0);
        step();
        flush = 1'b0;
        mem_ready = 1'b0;
        drive_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("flush_valid", 64'(mem_valid), 64'd0);
        check_val("flush_occ", 64'(occupancy), 64'd0);
        check_val("flush_mask", 64'(busy_rd_mask), 64'd0);
        check_val("flush_ex_ready", 64'(ex_ready), 64'd1);
        check_val("flush_mem_rden", 64'(mem_mem_rden), 64'd0);

        // Reset from FULL beats a same-cycle accept and flush
        drive_ex(1'b1, 32'h0000_0066, 5'd10, 1'b1, 1'b1, 1'b0);
        step();
        drive_ex(1'b1, 32'h0000_0077, 5'd12, 1'b1, 1'b0, 1'b1);
        step();
        check_val("pre_rst_occ", 64'(occupancy), 64'd2);
        rst = 1'b1;
        flush = 1'b1;
        drive_ex(1'b1, 32'h0000_0088, 5'd13, 1'b1, 1'b1, 1'b1);
        step();
        rst = 1'b0;
        flush = 1'b0;
        drive_ex(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("rst_full_ex_ready", 64'(ex_ready), 64'd1);
        check_val("rst_full_valid", 64'(mem_valid), 64'd0);
        check_val("rst_full_alu", 64'(mem_alu_result), 64'd0);
        check_val("rst_full_rs2", 64'(mem_rs2_data), 64'd0);
        check_val("rst_full_pc", 64'(mem_pc), 64'd0);
        check_val("rst_full_rd", 64'(mem_rd_addr), 64'd0);
        check_val("rst_full_ctrl", 64'({mem_rd_wren, mem_mem_wren, mem_mem_rden}), 64'd0);
        check_val("rst_full_mask", 64'(busy_rd_mask), 64'd0);
        check_val("rst_full_occ", 64'(occupancy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of result, store-data and PC fields.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ex_valid_i  input  1  EX stage presents a valid instruction.
REQ-005 SHALL have port ex_ready_o  output  1  buffer can accept an EX instruction this cycle.
REQ-006 SHALL have port ex_alu_result_i  input  DATA_W  ALU/shifter result (including shift-left output).
REQ-007 SHALL have port ex_rs2_data_i  input  DATA_W  store data.
REQ-008 SHALL have port ex_pc_i  input  DATA_W  instruction PC.
REQ-009 SHALL have port ex_rd_addr_i  input  5  destination register.
REQ-010 SHALL have ports ex_rd_wren_i, ex_mem_wren_i, ex_mem_rden_i  input  1 each  regfile write, store, and load controls.
REQ-011 SHALL have port flush_i  input  1  discard all held entries (branch taken/exception).
REQ-012 SHALL have port mem_ready_i  input  1  MEM stage accepts the head entry.
REQ-013 SHALL have port mem_valid_o  output  1  head entry valid.
REQ-014 SHALL have ports mem_alu_result_o, mem_rs2_data_o, mem_pc_o  output  DATA_W each; mem_rd_addr_o  output  5; mem_rd_wren_o, mem_mem_wren_o, mem_mem_rden_o  output  1 each  head entry fields.
REQ-015 SHALL have port busy_rd_mask_o  output  32  one-hot OR of rd of every valid held entry with rd_wren=1, for the no-forwarding hazard unit.
REQ-016 SHALL have port occupancy_o  output  2  number of valid entries (0..2).

Function
REQ-017 SHALL hold two entries: HEAD (drives mem_* outputs) and SKID (younger); states EMPTY (0), ONE (HEAD valid), FULL (both valid).
REQ-018 SHALL assert ex_ready_o = 1 exactly when state is not FULL, driven from registered state only (no combinational path from mem_ready_i).
REQ-019 SHALL accept an entry when ex_valid_i & ex_ready_o, and pop HEAD when mem_valid_o & mem_ready_i.
REQ-020 EMPTY: accept -> entry into HEAD, ONE; otherwise stay.
REQ-021 ONE: accept & pop -> new entry into HEAD, stay ONE; accept only -> entry into SKID, FULL; pop only -> EMPTY.
REQ-022 FULL: pop -> SKID moves to HEAD, SKID invalid, ONE; no pop -> hold all fields unchanged.
REQ-023 Entries SHALL leave in acceptance order; latency EX accept to mem_valid_o is exactly 1 cycle when empty.
REQ-024 An accepted entry with ex_rd_addr_i = 0 SHALL be stored with rd_wren = 0.
REQ-025 mem_* fields SHALL remain stable while mem_valid_o = 1 and mem_ready_i = 0.
REQ-026 flush_i = 1 SHALL clear both valid bits at the next edge, ignore any same-cycle accept and pop, and set state EMPTY; data fields need not change.
REQ-027 busy_rd_mask_o and occupancy_o SHALL be combinational from registered state; bit 0 of busy_rd_mask_o SHALL always be 0.
REQ-028 When mem_valid_o = 0, mem_rd_wren_o, mem_mem_wren_o and mem_mem_rden_o SHALL be 0 regardless of stored data.

Reset
REQ-029 rst_i = 1 at an edge SHALL set state EMPTY, all stored fields 0, so after that edge ex_ready_o = 1, mem_valid_o = 0, all mem_* outputs 0, busy_rd_mask_o = 0, occupancy_o = 0.
REQ-030 rst_i SHALL take priority over flush_i, accept and pop in the same cycle, including when FULL.

Verification
REQ-031 Reset, then accept result 0x0000_0F00 rd=5 rd_wren=1 with mem_ready_i=1 -> next cycle mem_valid_o=1, mem_alu_result_o=0x0000_0F00, busy_rd_mask_o=0x0000_0020, occupancy_o=1; following cycle empty.
REQ-032 mem_ready_i=0, accept A (rd=3) then B (rd=7) -> occupancy_o=2, ex_ready_o=0, busy_rd_mask_o=0x0000_0088, head stays A; raise mem_ready_i -> A then B emerge on consecutive cycles.
REQ-033 ONE state with simultaneous accept C and pop A -> next cycle head=C, occupancy_o=1, no entry lost or duplicated.
REQ-034 FULL, assert flush_i with ex_valid_i=1 and mem_ready_i=1 -> next cycle mem_valid_o=0, occupancy_o=0, busy_rd_mask_o=0, ex_ready_o=1.
REQ-035 Accept rd=0 rd_wren=1 -> mem_rd_wren_o=0, busy_rd_mask_o=0.
REQ-036 FULL with mem_ready_i=0, assert rst_i -> next cycle all outputs at reset values of REQ-029.
